// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style pipeline: bubble word, MEM-stage FSM states,
// write-back source selects and the data word returned by an aborted access.
package mips_pkg;

  localparam logic [15:0] NOP_WORD   = 16'h8040;
  localparam logic [15:0] ABORT_DATA = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MEM = 2'd1;
  localparam logic [1:0] RD_PC  = 2'd2;
  localparam logic [1:0] RD_IMM = 2'd3;

endpackage

// File: rtl/wait_counter.sv
// 8-bit wait counter for the memory request phase; tc_o flags the cycle in which
// the count of elapsed REQ cycles (this one included) reaches LIMIT.
module wait_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the ack-less REQ cycles already elapsed, so +1 is the current one.
  assign tc_o = (({1'b0, cnt_q} + 9'd1) == 9'(LIMIT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-memory requests from EX/MEM, stalls the
// front of the pipeline until ack or timeout, and loads the MEM/WB register.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               TIMEOUT  = 15,
  parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ex_inst,
  input  logic [WIDTH-1:0] ex_aluout,
  input  logic [WIDTH-1:0] ex_storedata,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             ex_regwrite,
  input  logic [1:0]       ex_regdata,
  input  logic [1:0]       ex_window,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stall,
  output logic [WIDTH-1:0] wb_inst,
  output logic [WIDTH-1:0] wb_aluout,
  output logic [WIDTH-1:0] wb_memdata,
  output logic             wb_regwrite,
  output logic [1:0]       wb_regdata,
  output logic [1:0]       wb_window,
  output logic             err
);

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] wb_inst_q, wb_inst_d;
  logic [WIDTH-1:0] wb_aluout_q, wb_aluout_d;
  logic [WIDTH-1:0] wb_memdata_q, wb_memdata_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic [1:0]       wb_regdata_q, wb_regdata_d;
  logic [1:0]       wb_window_q, wb_window_d;

  logic stall_c, bubble, ack_hit, tc, cnt_en, cnt_clr;

  wait_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  // An ack only counts while a request is actually outstanding.
  assign ack_hit = mem_req_q & mem_ack;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_d         = err_q;
    wb_inst_d     = ex_inst;
    wb_aluout_d   = ex_aluout;
    wb_memdata_d  = wb_memdata_q;
    wb_regwrite_d = ex_regwrite;
    wb_regdata_d  = ex_regdata;
    wb_window_d   = ex_window;
    stall_c       = 1'b0;
    bubble        = 1'b0;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b1;

    case (state_q)
      IDLE: begin
        if (ex_memread || ex_memwrite) begin
          stall_c     = 1'b1;
          bubble      = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = ex_memwrite;
          mem_addr_d  = ex_aluout;
          mem_wdata_d = ex_storedata;
          state_d     = REQ;
          if (ex_memread && ex_memwrite) begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack_hit) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!mem_we_q) begin
            wb_memdata_d = mem_rdata;
          end
        end else if (tc) begin
          mem_req_d    = 1'b0;
          state_d      = IDLE;
          err_d        = 1'b1;
          wb_memdata_d = WIDTH'(ABORT_DATA);
        end else begin
          stall_c = 1'b1;
          bubble  = 1'b1;
          cnt_en  = 1'b1;
          cnt_clr = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bubble) begin
      wb_inst_d     = NOP_INST;
      wb_aluout_d   = '0;
      wb_memdata_d  = '0;
      wb_regwrite_d = 1'b0;
      wb_regdata_d  = '0;
      wb_window_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_q         <= 1'b0;
      wb_inst_q     <= NOP_INST;
      wb_aluout_q   <= '0;
      wb_memdata_q  <= '0;
      wb_regwrite_q <= 1'b0;
      wb_regdata_q  <= '0;
      wb_window_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_q         <= err_d;
      wb_inst_q     <= wb_inst_d;
      wb_aluout_q   <= wb_aluout_d;
      wb_memdata_q  <= wb_memdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_regdata_q  <= wb_regdata_d;
      wb_window_q   <= wb_window_d;
    end
  end

  assign stall       = stall_c;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err         = err_q;
  assign wb_inst     = wb_inst_q;
  assign wb_aluout   = wb_aluout_q;
  assign wb_memdata  = wb_memdata_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_regdata  = wb_regdata_q;
  assign wb_window   = wb_window_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios followed by random instructions,
// each scored against a per-instruction timeline model of the memory stage.
module tb_mem_stage_ctrl;

  localparam int          TIMEOUT = 15;
  localparam logic [15:0] NOP     = 16'h8040;
  localparam int          NEVER   = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ex_inst, ex_aluout, ex_storedata;
  logic        ex_memread, ex_memwrite, ex_regwrite;
  logic [1:0]  ex_regdata, ex_window;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stall;
  logic [15:0] wb_inst, wb_aluout, wb_memdata;
  logic        wb_regwrite;
  logic [1:0]  wb_regdata, wb_window;
  logic        err;

  int          errors = 0;
  int          checks = 0;
  logic        err_exp = 1'b0;
  logic [15:0] memdata_exp = 16'h0000;

  mem_stage_ctrl #(
    .WIDTH    (16),
    .TIMEOUT  (TIMEOUT),
    .NOP_INST (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_inst      (ex_inst),
    .ex_aluout    (ex_aluout),
    .ex_storedata (ex_storedata),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_regwrite  (ex_regwrite),
    .ex_regdata   (ex_regdata),
    .ex_window    (ex_window),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .wb_inst      (wb_inst),
    .wb_aluout    (wb_aluout),
    .wb_memdata   (wb_memdata),
    .wb_regwrite  (wb_regwrite),
    .wb_regdata   (wb_regdata),
    .wb_window    (wb_window),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check16({tag, "_inst"}, wb_inst, NOP);
    check16({tag, "_alu"}, wb_aluout, 16'h0000);
    check16({tag, "_memdata"}, wb_memdata, 16'h0000);
    check1({tag, "_regwrite"}, wb_regwrite, 1'b0);
    check16({tag, "_sel"}, {12'h000, wb_regdata, wb_window}, 16'h0000);
  endtask

  task automatic check_pass(input string tag);
    check16({tag, "_inst"}, wb_inst, ex_inst);
    check16({tag, "_alu"}, wb_aluout, ex_aluout);
    check16({tag, "_memdata"}, wb_memdata, memdata_exp);
    check1({tag, "_regwrite"}, wb_regwrite, ex_regwrite);
    check16({tag, "_sel"}, {12'h000, wb_regdata, wb_window}, {12'h000, ex_regdata, ex_window});
    check1({tag, "_req"}, mem_req, 1'b0);
    check1({tag, "_err"}, err, err_exp);
  endtask

  // One instruction through the stage. d = ack-less REQ cycles before the ack.
  task automatic run_inst(input logic [15:0] inst, input logic [15:0] alu, input logic [15:0] sd,
                          input logic rd, input logic wr, input logic rw,
                          input logic [1:0] rsel, input logic [1:0] win,
                          input int d, input logic [15:0] ack_data);
    int r_cycles;
    bit aborted;
    ex_inst = inst; ex_aluout = alu; ex_storedata = sd;
    ex_memread = rd; ex_memwrite = wr; ex_regwrite = rw;
    ex_regdata = rsel; ex_window = win;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    #1;
    if (!(rd || wr)) begin
      check1("alu_stall", stall, 1'b0);
      tick();
      check_pass("alu");
    end else begin
      aborted  = (d + 1 > TIMEOUT);
      r_cycles = aborted ? TIMEOUT : d + 1;
      check1("idle_stall", stall, 1'b1);
      tick();
      err_exp = err_exp | (rd & wr);
      memdata_exp = 16'h0000;
      check_bubble("idle_bub");
      check1("idle_req", mem_req, 1'b1);
      check1("idle_we", mem_we, wr);
      check16("idle_addr", mem_addr, alu);
      check16("idle_wdata", mem_wdata, sd);
      check1("idle_err", err, err_exp);
      for (int c = 1; c <= r_cycles; c++) begin
        mem_ack   = (!aborted && c == d + 1);
        mem_rdata = mem_ack ? ack_data : 16'($urandom);
        #1;
        check1("req_stall", stall, (c != r_cycles));
        tick();
        if (c != r_cycles) begin
          check_bubble("wait_bub");
          check1("wait_req", mem_req, 1'b1);
          check1("wait_we", mem_we, wr);
          check16("wait_addr", mem_addr, alu);
          check16("wait_wdata", mem_wdata, sd);
        end else begin
          if (aborted) begin
            memdata_exp = 16'hFFFF;
            err_exp = 1'b1;
          end else if (!wr) begin
            memdata_exp = ack_data;
          end
          check_pass("done");
        end
      end
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_inst = 16'h0000; ex_aluout = 16'h0000; ex_storedata = 16'h0000;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b0;
    ex_regdata = 2'd0; ex_window = 2'd0;
    mem_rdata = 16'h0000; mem_ack = 1'b0;
    tick();
    tick();
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check16("rst_addr", mem_addr, 16'h0000);
    check16("rst_wdata", mem_wdata, 16'h0000);
    check_bubble("rst_wb");
    check1("rst_err", err, 1'b0);
    check1("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // ALU op, load with immediate ack, store with 3 waits
    run_inst(16'h1111, 16'h1234, 16'h5555, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 0, 16'h0000);
    run_inst(16'h2222, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 0, 16'hBEEF);
    check16("load_beef", wb_memdata, 16'hBEEF);
    run_inst(16'h3333, 16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 3, 16'h0000);
    // Load with ack in the cycle before the timeout cycle, then the timeout cycle itself
    run_inst(16'h4444, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, TIMEOUT - 2, 16'h1357);
    run_inst(16'h4545, 16'h0022, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, TIMEOUT - 1, 16'h2468);
    check1("ack_wins_err", err, 1'b0);
    // Load with no ack: abort
    run_inst(16'h5555, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, NEVER, 16'h0000);
    check16("abort_data", wb_memdata, 16'hFFFF);
    run_inst(16'h6666, 16'h0abc, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 0, 16'h0000);
    check1("err_sticky", err, 1'b1);
    // Read and write both set
    run_inst(16'h7777, 16'h0050, 16'h0f0f, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1, 16'hAAAA);

    // Reset in the second REQ cycle, then a stray ack
    ex_inst = 16'h8888; ex_aluout = 16'h0060; ex_storedata = 16'h0000;
    ex_memread = 1'b1; ex_memwrite = 1'b0; ex_regwrite = 1'b1;
    mem_ack = 1'b0;
    tick();
    tick();
    check1("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_exp = 1'b0;
    memdata_exp = 16'h0000;
    check1("rst_req_drop", mem_req, 1'b0);
    check16("rst_req_inst", wb_inst, NOP);
    check1("rst_req_err", err, 1'b0);
    check16("rst_req_addr", mem_addr, 16'h0000);
    ex_inst = 16'h9999; ex_aluout = 16'h0777; ex_memread = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check1("stray_ack_stall", stall, 1'b0);
    tick();
    check_pass("stray_ack");
    mem_ack = 1'b0;

    // Random instruction mix
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic rd, wr;
      kind = int'($urandom_range(0, 9));
      rd = (kind >= 4 && kind <= 6) || kind == 9;
      wr = (kind >= 7);
      run_inst(16'($urandom), 16'($urandom), 16'($urandom), rd, wr, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, TIMEOUT + 2)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives the data-memory request/acknowledge handshake. Issues loads and stores, stalls the upstream pipeline until the memory acknowledges or a timeout expires, and loads the MEM/WB outputs. Non-memory instructions pass through with one register stage.

## Interface
Parameters:
- `WIDTH`, default 16: data, address and instruction width.
- `TIMEOUT`, default 15: maximum REQ cycles without `mem_ack` before the access is aborted (1..255).
- `NOP_INST`, default 16'h8040: bubble instruction word.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_inst` in WIDTH: instruction from EX/MEM.
- `ex_aluout` in WIDTH: ALU result, used as memory address.
- `ex_storedata` in WIDTH: store data (Regb path).
- `ex_memread`, `ex_memwrite`, `ex_regwrite` in 1 each: EX/MEM control bits.
- `ex_regdata` in 2: write-back source select, passed through.
- `ex_window` in 2: register window, passed through.
- `mem_req` out 1: request to data memory, registered.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`, `mem_wdata` out WIDTH: stable while `mem_req`.
- `mem_rdata` in WIDTH: read data, sampled in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle completion strobe; ignored unless `mem_req` is high.
- `stall` out 1: combinational; freezes the PC and IF/ID, ID/EX and EX/MEM registers.
- `wb_inst`, `wb_aluout`, `wb_memdata` out WIDTH: MEM/WB outputs.
- `wb_regwrite` out 1, `wb_regdata` out 2, `wb_window` out 2: MEM/WB control.
- `err` out 1: sticky flag for timeout or an illegal read+write.

## Operation
- States: IDLE, REQ.
- IDLE, no memory op: MEM/WB loads the EX inputs. `wb_memdata` keeps its previous value. `stall`=0.
- IDLE with `ex_memread` or `ex_memwrite` set:
  - `stall`=1 and MEM/WB loads a bubble.
  - At the edge: address, data and `mem_we` are captured, `mem_req`<=1, state moves to REQ.
  - The EX inputs stay frozen because `stall` holds EX/MEM.
- Read and write both set: treated as a write, and `err` is set.
- REQ, `mem_ack`=0:
  - `stall`=1, bubble into MEM/WB, wait counter increments.
  - When the counter reaches TIMEOUT, the access aborts.
- REQ, `mem_ack`=1:
  - `stall`=0. At the edge MEM/WB loads the EX inputs, with `wb_memdata`<=`mem_rdata` for a read (unchanged for a write).
  - `mem_req`<=0, counter clears, state moves to IDLE.
- Abort:
  - `stall`=0 in the abort cycle. MEM/WB loads the EX inputs with `wb_memdata`<=16'hFFFF.
  - `err`<=1, `mem_req`<=0, state moves to IDLE.
- Bubble contents: `wb_inst`=NOP_INST, `wb_regwrite`=0, other wb fields 0.
- `err` clears only on `rst`.

## Timing
- Reset values:
  - state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wb_inst`=NOP_INST, all other wb outputs 0, `err`=0, counter 0.
- Non-memory instruction: 1-cycle latency, no stall.
- Memory op with `mem_ack` in the first REQ cycle: `stall` high 1 cycle, result in MEM/WB 2 edges after entering the stage.
- Each extra wait cycle adds one cycle of stall.
- Abort occurs in REQ cycle number TIMEOUT, counting the first REQ cycle as 1.
- `mem_ack` in the same cycle as the timeout: the ack wins, no `err`.
- Back-to-back memory ops: the next op enters REQ one cycle after the previous ack. IDLE always takes one stall cycle.
- `rst` asserted during REQ: `mem_req` drops at that edge. A later `mem_ack` while in IDLE is ignored.

## Structure
- Shared package `mips_pkg`:
  - NOP encoding 16'h8040.
  - State enum {IDLE, REQ}.
  - RegData select encodings.
  - Abort data constant 16'hFFFF.
- Sub-module `wait_counter`: 8-bit counter with clear/enable inputs and a terminal-count output compared against TIMEOUT. Everything else stays in `mem_stage_ctrl`.

## Test plan
- ALU op, `ex_aluout`=16'h1234, `ex_regwrite`=1 -> next cycle `wb_aluout`=16'h1234, `wb_regwrite`=1, `stall` never high.
- Load from addr 16'h0040 with ack in the first REQ cycle, `mem_rdata`=16'hBEEF -> `stall` high 1 cycle, `mem_req` high 1 cycle, `wb_memdata`=16'hBEEF.
- Store addr 16'h0010, data 16'h00AA, ack after 3 waits -> `mem_we`=1 with addr/data stable 4 cycles, bubbles (`wb_inst`=16'h8040) during the stall.
- Load with no ack, TIMEOUT=15 -> abort in REQ cycle 15, `wb_memdata`=16'hFFFF, `err`=1 and it stays set.
- `rst` in the second REQ cycle, then `mem_ack` pulse -> `mem_req`=0, all reset values, ack ignored.
- Read and write both set -> write issued (`mem_we`=1), `err`=1.
